// File: rtl/boid_frame_plotter.sv
// Boid frame plotter: snapshots CPU-written boid positions at frame end and
// emits one back-buffer pixel write per cycle for a square around each boid.
module boid_frame_plotter #(
    parameter int MAX_BOIDS    = 4,
    parameter int BOID_SIZE    = 2,
    parameter int VIDEO_WIDTH  = 640,
    parameter int VIDEO_HEIGHT = 480,
    localparam int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
    localparam int ADDR_WIDTH     = $clog2(VIDEO_WIDTH*VIDEO_HEIGHT)
) (
    input  logic                      clock,
    input  logic                      CPU_RESETN,
    input  logic                      cpu_we,
    input  logic [BITS_FOR_BOIDS-1:0] cpu_idx,
    input  logic [9:0]                cpu_x,
    input  logic [8:0]                cpu_y,
    input  logic                      cpu_valid,
    input  logic                      screen_end,
    output logic                      pix_we,
    output logic [ADDR_WIDTH-1:0]     pix_addr,
    output logic                      buf_clear,
    output logic                      front_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int IDX_W = BITS_FOR_BOIDS + 1;

    typedef enum logic [1:0] {IDLE, CLEAR, PLOT, DONE} state_t;

    state_t state, state_next;

    logic [9:0] slot_x [MAX_BOIDS];
    logic [8:0] slot_y [MAX_BOIDS];
    logic       slot_v [MAX_BOIDS];
    logic [9:0] snap_x [MAX_BOIDS];
    logic [8:0] snap_y [MAX_BOIDS];
    logic       snap_v [MAX_BOIDS];

    logic [BITS_FOR_BOIDS-1:0] boid_cnt;
    logic [1:0]                dy_cnt, dx_cnt;
    logic                      frame_start, cpu_hit, last_cand;
    logic [10:0]               cand_px;
    logic [9:0]                cand_py;
    logic                      cand_vis;
    logic [ADDR_WIDTH-1:0]     cand_addr;

    logic                  pix_we_p1;
    logic [ADDR_WIDTH-1:0] pix_addr_p1;
    logic                  done_p1;

    function automatic logic on_screen(input logic vld, input logic [10:0] px,
                                       input logic [9:0] py);
        return vld && (px < 11'(VIDEO_WIDTH)) && (py < 10'(VIDEO_HEIGHT));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] pixel_addr(input logic [10:0] px,
                                                         input logic [9:0] py);
        return ADDR_WIDTH'(py) * ADDR_WIDTH'(VIDEO_WIDTH) + ADDR_WIDTH'(px);
    endfunction

    assign cpu_hit     = cpu_we && ({1'b0, cpu_idx} < IDX_W'(MAX_BOIDS));
    assign frame_start = (state == IDLE) && screen_end;
    assign last_cand   = (boid_cnt == BITS_FOR_BOIDS'(MAX_BOIDS - 1)) &&
                         (dy_cnt == 2'(BOID_SIZE - 1)) && (dx_cnt == 2'(BOID_SIZE - 1));

    // Widened sums so a boid at the screen edge cannot wrap back on-screen
    assign cand_px   = {1'b0, snap_x[boid_cnt]} + {9'b0, dx_cnt};
    assign cand_py   = {1'b0, snap_y[boid_cnt]} + {8'b0, dy_cnt};
    assign cand_vis  = on_screen(snap_v[boid_cnt], cand_px, cand_py);
    assign cand_addr = pixel_addr(cand_px, cand_py);

    always_ff @(posedge clock) begin
        if (!CPU_RESETN) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        buf_clear  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (screen_end) state_next = CLEAR;
            end
            CLEAR: begin
                buf_clear  = 1'b1;
                state_next = PLOT;
            end
            PLOT:    if (last_cand) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Live slots take CPU writes at any time; the snapshot sees a same-cycle write
    always_ff @(posedge clock) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < MAX_BOIDS; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
                slot_v[i] <= 1'b0;
                snap_x[i] <= '0;
                snap_y[i] <= '0;
                snap_v[i] <= 1'b0;
            end
        end else begin
            if (cpu_hit) begin
                slot_x[cpu_idx] <= cpu_x;
                slot_y[cpu_idx] <= cpu_y;
                slot_v[cpu_idx] <= cpu_valid;
            end
            if (frame_start) begin
                for (int i = 0; i < MAX_BOIDS; i++) begin
                    if (cpu_hit && (cpu_idx == BITS_FOR_BOIDS'(i))) begin
                        snap_x[i] <= cpu_x;
                        snap_y[i] <= cpu_y;
                        snap_v[i] <= cpu_valid;
                    end else begin
                        snap_x[i] <= slot_x[i];
                        snap_y[i] <= slot_y[i];
                        snap_v[i] <= slot_v[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!CPU_RESETN || (state != PLOT) || last_cand) begin
            boid_cnt <= '0;
            dy_cnt   <= '0;
            dx_cnt   <= '0;
        end else if (dx_cnt == 2'(BOID_SIZE - 1)) begin
            dx_cnt <= '0;
            if (dy_cnt == 2'(BOID_SIZE - 1)) begin
                dy_cnt   <= '0;
                boid_cnt <= boid_cnt + 1'b1;
            end else begin
                dy_cnt <= dy_cnt + 1'b1;
            end
        end else begin
            dx_cnt <= dx_cnt + 1'b1;
        end
    end

    // p0 -> p1: candidate pixel registered onto the buffer write port
    always_ff @(posedge clock) begin
        if (!CPU_RESETN) begin
            pix_we_p1   <= 1'b0;
            pix_addr_p1 <= '0;
            done_p1     <= 1'b0;
            front_sel   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pix_we_p1 <= (state == PLOT) && cand_vis;
            if (state == PLOT) pix_addr_p1 <= cand_addr;
            done_p1 <= (state == DONE);
            if (frame_start) front_sel <= ~front_sel;
            if (screen_end && (state != IDLE)) overrun <= 1'b1;
        end
    end

    assign pix_we   = pix_we_p1;
    assign pix_addr = pix_addr_p1;
    assign done     = done_p1;

endmodule

// File: tb/tb_boid_frame_plotter.sv
// Bench for boid_frame_plotter: directed and randomised frames checked against a
// per-frame list of expected pixel writes built from the slot contents.
module tb_boid_frame_plotter;

    localparam int MB     = 4;
    localparam int BS     = 2;
    localparam int VW     = 640;
    localparam int VH     = 480;
    localparam int AW     = $clog2(VW*VH);
    localparam int NC     = MB*BS*BS;
    localparam int DONE_C = 3 + NC;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          CPU_RESETN, cpu_we, cpu_valid, screen_end;
    logic [1:0]    cpu_idx;
    logic [9:0]    cpu_x;
    logic [8:0]    cpu_y;
    logic          pix_we, buf_clear, front_sel, busy, done, overrun;
    logic [AW-1:0] pix_addr;

    logic          b_we, b_valid, b_se;
    logic [2:0]    b_idx;
    logic [9:0]    b_x;
    logic [8:0]    b_y;
    logic          b_pix_we, b_buf_clear, b_front_sel, b_busy, b_done, b_overrun;
    logic [AW-1:0] b_pix_addr;

    boid_frame_plotter #(.MAX_BOIDS(MB), .BOID_SIZE(BS), .VIDEO_WIDTH(VW), .VIDEO_HEIGHT(VH)) dut (
        .clock(clock), .CPU_RESETN(CPU_RESETN), .cpu_we(cpu_we), .cpu_idx(cpu_idx),
        .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_valid(cpu_valid), .screen_end(screen_end),
        .pix_we(pix_we), .pix_addr(pix_addr), .buf_clear(buf_clear), .front_sel(front_sel),
        .busy(busy), .done(done), .overrun(overrun)
    );

    boid_frame_plotter #(.MAX_BOIDS(5), .BOID_SIZE(1), .VIDEO_WIDTH(VW), .VIDEO_HEIGHT(VH)) dut5 (
        .clock(clock), .CPU_RESETN(CPU_RESETN), .cpu_we(b_we), .cpu_idx(b_idx),
        .cpu_x(b_x), .cpu_y(b_y), .cpu_valid(b_valid), .screen_end(b_se),
        .pix_we(b_pix_we), .pix_addr(b_pix_addr), .buf_clear(b_buf_clear), .front_sel(b_front_sel),
        .busy(b_busy), .done(b_done), .overrun(b_overrun)
    );

    int checks = 0;
    int errors = 0;
    int m_x [MB];
    int m_y [MB];
    bit m_v [MB];
    bit m_front, m_over;
    bit exp_we [NC];
    int exp_addr [NC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_write(input int idx, input int x, input int y, input int v);
        if (idx >= 0 && idx < MB) begin
            m_x[idx] = x;
            m_y[idx] = y;
            m_v[idx] = (v != 0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MB; i++) model_write(i, 0, 0, 0);
        m_front = 1'b0;
        m_over  = 1'b0;
    endtask

    // Expected write list for one frame, candidate k reaches the outputs in cycle 3+k
    task automatic model_snapshot();
        int k, px, py;
        k = 0;
        for (int b = 0; b < MB; b++)
            for (int dy = 0; dy < BS; dy++)
                for (int dx = 0; dx < BS; dx++) begin
                    px = m_x[b] + dx;
                    py = m_y[b] + dy;
                    exp_we[k]   = m_v[b] && (px < VW) && (py < VH);
                    exp_addr[k] = py*VW + px;
                    k++;
                end
    endtask

    task automatic wr_slot(input int idx, input int x, input int y, input int v);
        cpu_we = 1'b1; cpu_idx = 2'(idx); cpu_x = 10'(x); cpu_y = 9'(y); cpu_valid = (v != 0);
        step();
        cpu_we = 1'b0;
        model_write(idx, x, y, v);
    endtask

    // se2: cycle of a second screen_end (-1 none); wc: cycle of a CPU write (-1 none)
    task automatic run_frame(input int se2, input int wc, input int wi, input int wx,
                             input int wy, input int wv);
        bit ovr_hit;
        ovr_hit = (se2 >= 1) && (se2 < DONE_C);
        for (int c = 0; c <= DONE_C + 1; c++) begin
            screen_end = (c == 0) || (c == se2);
            cpu_we     = (c == wc);
            if (c == wc) begin
                cpu_idx = 2'(wi); cpu_x = 10'(wx); cpu_y = 9'(wy); cpu_valid = (wv != 0);
            end
            if (c == 0) begin
                if (wc == 0) model_write(wi, wx, wy, wv);
                model_snapshot();
            end
            chk("busy", 32'(busy), 32'(c >= 1 && c <= DONE_C - 1));
            chk("buf_clear", 32'(buf_clear), 32'(c == 1));
            chk("done", 32'(done), 32'(c == DONE_C));
            chk("front_sel", 32'(front_sel), 32'(c == 0 ? m_front : !m_front));
            chk("overrun", 32'(overrun), 32'(m_over || (ovr_hit && c > se2)));
            if (c >= 3 && c < 3 + NC) begin
                chk("pix_we", 32'(pix_we), 32'(exp_we[c-3]));
                if (exp_we[c-3]) chk("pix_addr", 32'(pix_addr), 32'(exp_addr[c-3]));
            end else begin
                chk("pix_we_idle", 32'(pix_we), 32'd0);
            end
            step();
            if (c == wc && wc != 0) model_write(wi, wx, wy, wv);
        end
        screen_end = 1'b0;
        cpu_we     = 1'b0;
        m_front    = !m_front;
        if (ovr_hit) m_over = 1'b1;
    endtask

    function automatic int rand_x();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(630, 1023)) : int'($urandom_range(0, 639));
    endfunction

    function automatic int rand_y();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(470, 511)) : int'($urandom_range(0, 479));
    endfunction

    initial begin
        int n_we;
        CPU_RESETN = 1'b0; cpu_we = 1'b0; cpu_idx = '0; cpu_x = '0; cpu_y = '0;
        cpu_valid = 1'b0; screen_end = 1'b0;
        b_we = 1'b0; b_idx = '0; b_x = '0; b_y = '0; b_valid = 1'b0; b_se = 1'b0;
        model_reset();
        step();
        step();
        CPU_RESETN = 1'b1;

        chk("rst_pix_we", 32'(pix_we), 32'd0);
        chk("rst_pix_addr", 32'(pix_addr), 32'd0);
        chk("rst_buf_clear", 32'(buf_clear), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_front_sel", 32'(front_sel), 32'd0);

        // single boid at (10,5): addresses 3210, 3211, 3850, 3851
        wr_slot(1, 10, 5, 1);
        run_frame(-1, -1, 0, 0, 0, 0);
        chk("front_after_first", 32'(front_sel), 32'd1);

        // bottom-right corner: only one of four candidates lands on screen
        wr_slot(1, 0, 0, 0);
        wr_slot(0, 639, 479, 1);
        run_frame(-1, -1, 0, 0, 0, 0);

        // frame end during plotting raises overrun, front_sel toggles once
        wr_slot(2, rand_x(), rand_y(), 1);
        run_frame(5, -1, 0, 0, 0, 0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // write during PLOT affects only the following frame
        run_frame(-1, 8, 2, 300, 200, 1);
        run_frame(-1, -1, 0, 0, 0, 0);

        // all hidden: no writes, done still on time
        for (int i = 0; i < MB; i++) wr_slot(i, rand_x(), rand_y(), 0);
        run_frame(-1, -1, 0, 0, 0, 0);

        // randomised frames, some with a write-through on the frame-end cycle
        for (int f = 0; f < 6; f++) begin
            for (int w = 0; w < 3; w++)
                wr_slot(int'($urandom_range(0, MB - 1)), rand_x(), rand_y(), int'($urandom_range(0, 3) != 0));
            if (f % 2 == 0)
                run_frame(-1, 0, int'($urandom_range(0, MB - 1)), rand_x(), rand_y(), 1);
            else
                run_frame(-1, -1, 0, 0, 0, 0);
        end

        // reset mid-PLOT
        for (int i = 0; i < MB; i++) wr_slot(i, 40*i + 20, 30, 1);
        screen_end = 1'b1;
        step();
        screen_end = 1'b0;
        for (int c = 1; c < 8; c++) step();
        CPU_RESETN = 1'b0;
        step();
        CPU_RESETN = 1'b1;
        model_reset();
        chk("mid_rst_pix_we", 32'(pix_we), 32'd0);
        chk("mid_rst_pix_addr", 32'(pix_addr), 32'd0);
        chk("mid_rst_buf_clear", 32'(buf_clear), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_front_sel", 32'(front_sel), 32'd0);
        n_we = 0;
        for (int c = 0; c < 14; c++) begin
            n_we += int'(pix_we) + int'(done);
            step();
        end
        chk("mid_rst_quiet", 32'(n_we), 32'd0);
        wr_slot(3, 100, 50, 1);
        run_frame(-1, -1, 0, 0, 0, 0);

        // out-of-range slot index on a five-slot instance
        b_we = 1'b1; b_idx = 3'd0; b_x = 10'd100; b_y = 9'd100; b_valid = 1'b1; step();
        b_idx = 3'd5; b_x = 10'd200; b_y = 9'd200; step();
        b_idx = 3'd7; b_x = 10'd1;   b_y = 9'd1;   step();
        b_idx = 3'd4; b_x = 10'd2;   b_y = 9'd3;   step();
        b_we = 1'b0;
        b_se = 1'b1;
        step();
        b_se = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk("b_pix_we", 32'(b_pix_we), 32'(c == 3 || c == 7));
            if (c == 3) chk("b_pix_addr0", 32'(b_pix_addr), 32'd64100);
            if (c == 7) chk("b_pix_addr4", 32'(b_pix_addr), 32'd1922);
            chk("b_done", 32'(b_done), 32'(c == 8));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
